result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer_pkg.sv | 10 +
 rtl/result_serializer.sv | 143 ++++++++++++++
 tb/tb_result_serializer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_serializer_pkg.sv
// Shared calculator package: matrix geometry and serializer state encoding.
package result_serializer_pkg;

    localparam int unsigned CALC_DIM    = 3;
    localparam int unsigned CALC_ELEM_W = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/result_serializer.sv
// Captures a DIM x DIM calculator result and streams it out row-major over valid/ready.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int unsigned DIM    = CALC_DIM,
    parameter int unsigned ELEM_W = CALC_ELEM_W
) (
    input  logic                      Clock,
    input  logic                      reset,
    input  logic [DIM*DIM*ELEM_W-1:0] Result,
    input  logic                      done,
    output logic [ELEM_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_row,
    output logic [1:0]                out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned NUM_ELEM = DIM * DIM;
    localparam int unsigned BUS_W    = NUM_ELEM * ELEM_W;
    localparam int unsigned BASE_W   = $clog2(BUS_W);

    logic [0:0]        state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [BUS_W-1:0]  shadow_q, shadow_d;
    logic              overrun_q, overrun_d;
    logic [ELEM_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_row_q, out_row_d;
    logic [1:0]        out_col_q, out_col_d;
    logic              out_last_q, out_last_d;
    logic              xfer;
    logic              at_last;
    logic              capture;
    logic [BASE_W-1:0] base;

    // Next-state, index advance, capture/overrun decisions and next output values.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        shadow_d   = shadow_q;
        overrun_d  = overrun_q;
        capture    = 1'b0;
        xfer       = (state_q == ST_SEND) && out_ready;
        at_last    = (row_q == 2'(DIM - 1)) && (col_q == 2'(DIM - 1));

        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    capture = 1'b1;
                end
            end
            ST_SEND: begin
                if (xfer && at_last) begin
                    // A done landing on the final transfer chains straight into the next matrix.
                    if (done) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        row_d   = 2'd0;
                        col_d   = 2'd0;
                    end
                end else begin
                    if (xfer) begin
                        if (col_q == 2'(DIM - 1)) begin
                            col_d = 2'd0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 2'd1;
                        end
                    end
                    if (done) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            shadow_d = Result;
            row_d    = 2'd0;
            col_d    = 2'd0;
            state_d  = ST_SEND;
        end

        // Outputs are registered from next-state values so they line up with state_q.
        base       = BASE_W'((32'(row_d) * DIM + 32'(col_d)) * ELEM_W);
        out_data_d = '0;
        out_row_d  = 2'd0;
        out_col_d  = 2'd0;
        out_last_d = 1'b0;
        if (state_d == ST_SEND) begin
            out_data_d = shadow_d[base +: ELEM_W];
            out_row_d  = row_d;
            out_col_d  = col_d;
            out_last_d = (row_d == 2'(DIM - 1)) && (col_d == 2'(DIM - 1));
        end
    end

    // Control state and registered outputs with synchronous reset.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            overrun_q  <= 1'b0;
            out_data_q <= '0;
            out_row_q  <= 2'd0;
            out_col_q  <= 2'd0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            overrun_q  <= overrun_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            out_last_q <= out_last_d;
        end
    end

    // Shadow copy of the result; contents are don't-care until the first capture.
    always_ff @(posedge Clock) begin
        shadow_q <= shadow_d;
    end

    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: table-driven stall test plus hand-written corner sequences.
module tb_result_serializer;

    localparam int unsigned DIM    = 3;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned NE     = DIM * DIM;
    localparam int unsigned BUS_W  = NE * ELEM_W;

    logic              Clock;
    logic              reset;
    logic [BUS_W-1:0]  Result;
    logic              done;
    logic [ELEM_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;
    logic              busy;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [1:0]  exp_row;
        logic [1:0]  exp_col;
        logic        exp_last;
    } vec_t;

    vec_t vecs[26];

    result_serializer #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
        .Clock     (Clock),
        .reset     (reset),
        .Result    (Result),
        .done      (done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [BUS_W-1:0] mk(input int first);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(NE); k++) r[k*ELEM_W +: ELEM_W] = 16'(first + k);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Checks one full element: valid, data, indices, last flag and busy.
    task automatic chk_elem(input string name, input int k, input logic [15:0] exp_data);
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " data"},  32'(out_data),  32'(exp_data));
        chk({name, " row"},   32'(out_row),   32'(k / 3));
        chk({name, " col"},   32'(out_col),   32'(k % 3));
        chk({name, " last"},  32'(out_last),  32'(k == 8));
        chk({name, " busy"},  32'(busy),      32'd1);
    endtask

    task automatic chk_idle(input string name);
        chk({name, " idle valid"}, 32'(out_valid), 32'd0);
        chk({name, " idle busy"},  32'(busy),      32'd0);
        chk({name, " idle data"},  32'(out_data),  32'd0);
        chk({name, " idle rc"},    32'({out_row, out_col, out_last}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic [BUS_W-1:0] data);
        Result = data;
        done   = 1'b1;
        tick();
        done   = 1'b0;
    endtask

    initial begin
        logic [BUS_W-1:0] r;

        // Stall pattern 1,0,0 repeating: element e held from cycle 3e-2 through its transfer at 3e.
        vecs[0]  = '{1'b1, 1'b1, 16'd1, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'd2, 2'd0, 2'd1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'd2, 2'd0, 2'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'd2, 2'd0, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'd3, 2'd0, 2'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'd3, 2'd0, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'd3, 2'd0, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'd4, 2'd1, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'd4, 2'd1, 2'd0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'd4, 2'd1, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'd5, 2'd1, 2'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'd5, 2'd1, 2'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'd5, 2'd1, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'd6, 2'd1, 2'd2, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 16'd6, 2'd1, 2'd2, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'd6, 2'd1, 2'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 16'd7, 2'd2, 2'd0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 16'd7, 2'd2, 2'd0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 16'd7, 2'd2, 2'd0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 16'd8, 2'd2, 2'd1, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 16'd8, 2'd2, 2'd1, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 16'd8, 2'd2, 2'd1, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 16'd9, 2'd2, 2'd2, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 16'd9, 2'd2, 2'd2, 1'b1};
        vecs[24] = '{1'b1, 1'b1, 16'd9, 2'd2, 2'd2, 1'b1};
        vecs[25] = '{1'b1, 1'b0, 16'd0, 2'd0, 2'd0, 1'b0};

        reset     = 1'b1;
        done      = 1'b0;
        out_ready = 1'b1;
        Result    = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk_idle("reset");
        chk("reset overrun", 32'(overrun), 32'd0);

        // Full matrix at full throughput: 9 consecutive valid cycles.
        start(mk(1));
        for (int k = 0; k < 9; k++) begin
            chk_elem("stream", k, 16'(k + 1));
            tick();
        end
        chk_idle("stream end");
        chk("stream overrun", 32'(overrun), 32'd0);

        // Back-pressure table.
        start(mk(1));
        for (int c = 0; c < 26; c++) begin
            out_ready = vecs[c].ready;
            chk($sformatf("stall[%0d]", c),
                32'({out_valid, out_data, out_row, out_col, out_last}),
                32'({vecs[c].exp_valid, vecs[c].exp_data, vecs[c].exp_row,
                     vecs[c].exp_col, vecs[c].exp_last}));
            tick();
        end
        out_ready = 1'b1;

        // Overrun: second done three cycles after the first must be dropped.
        start(mk(1));
        for (int k = 0; k < 9; k++) begin
            chk_elem("ovr", k, 16'(k + 1));
            if (k >= 3) chk("ovr sticky", 32'(overrun), 32'd1);
            else        chk("ovr clear",  32'(overrun), 32'd0);
            if (k == 2) begin
                Result = mk(100);
                done   = 1'b1;
            end else begin
                done = 1'b0;
            end
            tick();
        end
        chk_idle("ovr end");
        chk("ovr held", 32'(overrun), 32'd1);
        do_reset();
        chk("ovr reset", 32'(overrun), 32'd0);

        // Back-to-back: done on the final transfer chains into 10..18 with no gap.
        start(mk(1));
        for (int k = 0; k < 9; k++) begin
            chk_elem("b2b first", k, 16'(k + 1));
            if (k == 8) begin
                Result = mk(10);
                done   = 1'b1;
            end
            tick();
        end
        done = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk_elem("b2b second", k, 16'(k + 10));
            tick();
        end
        chk_idle("b2b end");
        chk("b2b overrun", 32'(overrun), 32'd0);

        // Reset after the 4th transfer aborts, with a pending overrun cleared.
        start(mk(1));
        for (int k = 0; k < 4; k++) begin
            chk_elem("abort", k, 16'(k + 1));
            done = (k == 1);
            tick();
        end
        done = 1'b0;
        chk("abort pre overrun", 32'(overrun), 32'd1);
        chk_elem("abort pre", 4, 16'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("abort");
        chk("abort overrun", 32'(overrun), 32'd0);
        tick();
        chk_idle("abort stays");
        start(mk(40));
        chk_elem("restart", 0, 16'd40);
        for (int k = 0; k < 9; k++) tick();
        chk_idle("restart end");

        // done coincident with reset is ignored.
        Result = mk(1);
        done   = 1'b1;
        reset  = 1'b1;
        tick();
        done  = 1'b0;
        reset = 1'b0;
        tick();
        chk_idle("done+reset");

        // Bit-exact passthrough of extreme values.
        r = mk(0);
        r[0*ELEM_W +: ELEM_W] = 16'hFFFF;
        r[1*ELEM_W +: ELEM_W] = 16'h8000;
        r[2*ELEM_W +: ELEM_W] = 16'h7FFF;
        r[8*ELEM_W +: ELEM_W] = 16'hA5C3;
        start(r);
        for (int k = 0; k < 9; k++) begin
            chk_elem("exact", k, r[k*ELEM_W +: ELEM_W]);
            tick();
        end
        chk_idle("exact end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
